// File: rtl/regfile_arbiter.sv
// Purpose: sole owner of the card regfile ports; round-robin write arbitration plus scan/single read sequencing.
// Latency: write request to regfile write is 2 cycles when uncontended; a read address is issued 1 cycle after acceptance and its valid follows 1 cycle later.
// Backpressure: each requester has a 1-entry buffer (wr_ready = buffer empty); a request into a full buffer is dropped and sets sticky wr_overflow.
module regfile_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  // write requesters
  input  logic [NUM_REQ-1:0]        wr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        wr_ready,
  output logic [NUM_REQ-1:0]        wr_ack,
  output logic                      wr_overflow,
  // regfile write port
  output logic                      regfile_w_enable,
  output logic [ADDR_W-1:0]         regfile_w_address,
  output logic [DATA_W-1:0]         regfile_w_data,
  // table scan
  input  logic                      scan_start,
  input  logic [ADDR_W:0]           scan_len,
  output logic                      scan_busy,
  output logic                      scan_valid,
  output logic                      scan_done,
  // single read
  input  logic                      rd_req,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_valid,
  // regfile read port
  output logic [ADDR_W-1:0]         regfile_r_address
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]  buf_addr_q [NUM_REQ];
  logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
  logic [RR_W-1:0]    rr_q, rr_d;
  logic               overflow_q, overflow_d;
  logic               w_en_q, w_en_d;
  logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic [DATA_W-1:0]  w_data_q, w_data_d;
  logic [NUM_REQ-1:0] wr_ack_q, wr_ack_d;

  logic               gnt_vld;
  logic [RR_W-1:0]    gnt_idx;
  logic [RR_W-1:0]    cand;
  logic [NUM_REQ-1:0] gnt_oh;

  // Round-robin pick: first pending entry after the last grant, wrapping; the
  // loop runs far-to-near so the nearest pending entry is the one that sticks.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = RR_W'((int'(rr_q) + k) % NUM_REQ);
      if (pending_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  // Next-state of the write path: drain the granted buffer, fill empty buffers
  // that see a request, flag requests that land on a full buffer.
  always_comb begin
    pending_d  = (pending_q & ~gnt_oh) | (wr_req & ~pending_q);
    overflow_d = overflow_q | (|(wr_req & pending_q));
    rr_d       = gnt_vld ? gnt_idx : rr_q;
    w_en_d     = gnt_vld;
    wr_ack_d   = gnt_oh;
    w_addr_d   = gnt_vld ? buf_addr_q[gnt_idx] : w_addr_q;
    w_data_d   = gnt_vld ? buf_data_q[gnt_idx] : w_data_q;
  end

  // Write-path control registers; reset discards anything still buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      rr_q       <= '0;
      w_en_q     <= 1'b0;
      wr_ack_q   <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      rr_q       <= rr_d;
      w_en_q     <= w_en_d;
      wr_ack_q   <= wr_ack_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
    end
  end

  // Buffer payloads are only meaningful while pending, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_req[i] && !pending_q[i]) begin
        buf_addr_q[i] <= wr_addr[i*ADDR_W +: ADDR_W];
        buf_data_q[i] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_ready          = ~pending_q;
  assign wr_ack            = wr_ack_q;
  assign wr_overflow       = overflow_q;
  assign regfile_w_enable  = w_en_q;
  assign regfile_w_address = w_addr_q;
  assign regfile_w_data    = w_data_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_SCAN   = 2'd1,
    R_SINGLE = 2'd2
  } rstate_t;

  rstate_t           state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_nxt;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic              scan_valid_q, scan_valid_d;
  logic              scan_done_q, scan_done_d;
  logic              rd_valid_q, rd_valid_d;
  logic              scan_go;
  logic              rd_go;
  logic              scan_tail;

  // cnt_q counts addresses already issued; cnt_q == len_q is the extra cycle
  // in which the last entry's data is still on the read port.
  assign cnt_nxt   = cnt_q + 1'b1;
  assign scan_go   = scan_start && (scan_len != '0);
  // The requester still holds rd_req in the cycle rd_valid is shown, so that
  // cycle must not start a second read of the same request.
  assign rd_go     = rd_req && !rd_valid_q;
  assign scan_tail = (cnt_q == len_q);

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= R_IDLE;
    else     state_q <= state_d;
  end

  // Read FSM next state: a scan outranks a pending single read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE: begin
        if (scan_go)    state_d = R_SCAN;
        else if (rd_go) state_d = R_SINGLE;
      end
      R_SCAN:   if (scan_tail) state_d = R_IDLE;
      R_SINGLE: state_d = R_IDLE;
      default:  state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs: next read address, scan counter and the one-cycle-late
  // valid/done strobes that line up with regfile read data.
  always_comb begin
    cnt_d        = cnt_q;
    len_d        = len_q;
    r_addr_d     = r_addr_q;
    scan_valid_d = 1'b0;
    scan_done_d  = 1'b0;
    rd_valid_d   = 1'b0;
    scan_busy    = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (scan_go) begin
          cnt_d    = '0;
          len_d    = scan_len;
          r_addr_d = '0;
        end else if (rd_go) begin
          r_addr_d = rd_addr;
        end
        // An empty scan just acknowledges itself.
        if (scan_start && (scan_len == '0)) scan_done_d = 1'b1;
      end
      R_SCAN: begin
        scan_busy = 1'b1;
        if (scan_tail) begin
          scan_done_d = 1'b1;
        end else begin
          scan_valid_d = 1'b1;
          cnt_d        = cnt_nxt;
          if (cnt_nxt < len_q) r_addr_d = cnt_nxt[ADDR_W-1:0];
        end
      end
      R_SINGLE: rd_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Read datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      len_q        <= '0;
      r_addr_q     <= '0;
      scan_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      r_addr_q     <= r_addr_d;
      scan_valid_q <= scan_valid_d;
      scan_done_q  <= scan_done_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign scan_valid        = scan_valid_q;
  assign scan_done         = scan_done_q;
  assign rd_valid          = rd_valid_q;
  assign regfile_r_address = r_addr_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: scenario tasks drive stimulus and push expected events;
// negedge monitors pop and compare every regfile write and every read-side strobe.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_regfile_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 5;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        wr_req = '0;
  logic [NUM_REQ*ADDR_W-1:0] wr_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] wr_data = '0;
  logic [NUM_REQ-1:0]        wr_ready;
  logic [NUM_REQ-1:0]        wr_ack;
  logic                      wr_overflow;
  logic                      regfile_w_enable;
  logic [ADDR_W-1:0]         regfile_w_address;
  logic [DATA_W-1:0]         regfile_w_data;
  logic                      scan_start = 1'b0;
  logic [ADDR_W:0]           scan_len = '0;
  logic                      scan_busy;
  logic                      scan_valid;
  logic                      scan_done;
  logic                      rd_req = 1'b0;
  logic [ADDR_W-1:0]         rd_addr = '0;
  logic                      rd_valid;
  logic [ADDR_W-1:0]         regfile_r_address;

  regfile_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_ack(wr_ack), .wr_overflow(wr_overflow),
    .regfile_w_enable(regfile_w_enable), .regfile_w_address(regfile_w_address),
    .regfile_w_data(regfile_w_data),
    .scan_start(scan_start), .scan_len(scan_len), .scan_busy(scan_busy),
    .scan_valid(scan_valid), .scan_done(scan_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .regfile_r_address(regfile_r_address)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] ack;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    int                 cyc;
  } wexp_t;

  // kind: 0 = scan_valid, 1 = rd_valid, 2 = scan_done
  typedef struct {
    int                kind;
    logic [ADDR_W-1:0] addr;
    int                cyc;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int    cyc = 0;
  int    n_pass = 0;
  int    n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor
  wexp_t we;
  always @(negedge clk) begin
    if (regfile_w_enable === 1'b1) begin
      n_total++;
      if (wq.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%0d ack=%b at cyc %0d, required no write",
                 regfile_w_address, regfile_w_data, wr_ack, cyc);
      end else begin
        we = wq.pop_front();
        if (wr_ack !== we.ack || regfile_w_address !== we.addr ||
            regfile_w_data !== we.data || cyc != we.cyc)
          $display("FAIL write: got ack=%b addr=%0d data=%0d cyc=%0d, required ack=%b addr=%0d data=%0d cyc=%0d",
                   wr_ack, regfile_w_address, regfile_w_data, cyc, we.ack, we.addr, we.data, we.cyc);
        else
          n_pass++;
      end
    end else if (wr_ack !== '0) begin
      n_total++;
      $display("FAIL stray_ack: got wr_ack=%b without w_enable at cyc %0d, required 000", wr_ack, cyc);
    end
  end

  // Read monitor: valid strobes refer to the address shown one cycle earlier
  rexp_t       re;
  logic        ev;
  logic [ADDR_W-1:0] prev_raddr = '0;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      ev = (k == 0) ? scan_valid : (k == 1) ? rd_valid : scan_done;
      if (ev === 1'b1) begin
        n_total++;
        if (rq.size() == 0) begin
          $display("FAIL unexpected_read_event: got kind=%0d at cyc %0d, required none", k, cyc);
        end else begin
          re = rq.pop_front();
          if (re.kind != k || re.cyc != cyc || (k != 2 && prev_raddr !== re.addr))
            $display("FAIL read_event: got kind=%0d addr=%0d cyc=%0d, required kind=%0d addr=%0d cyc=%0d",
                     k, prev_raddr, cyc, re.kind, re.addr, re.cyc);
          else
            n_pass++;
        end
      end
    end
    prev_raddr = regfile_r_address;
  end

  task automatic set_wr(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_req[i] = 1'b1;
    wr_addr[i*ADDR_W +: ADDR_W] = a;
    wr_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (wr_ready !== 3'b111) $display("FAIL reset_wr_ready: got %b, required 111", wr_ready);
    else n_pass++;
    n_total++;
    if ({wr_ack, wr_overflow, regfile_w_enable} !== 5'b0)
      $display("FAIL reset_write_outputs: got ack=%b ovf=%b wen=%b, required 0", wr_ack, wr_overflow, regfile_w_enable);
    else n_pass++;
    n_total++;
    if ({regfile_w_address, regfile_w_data, regfile_r_address} !== '0)
      $display("FAIL reset_addr_data: got waddr=%0d wdata=%0d raddr=%0d, required 0",
               regfile_w_address, regfile_w_data, regfile_r_address);
    else n_pass++;
    n_total++;
    if ({scan_busy, scan_valid, scan_done, rd_valid} !== 4'b0)
      $display("FAIL reset_read_outputs: got %b, required 0000", {scan_busy, scan_valid, scan_done, rd_valid});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int t;
    @(negedge clk);
    t = cyc;
    set_wr(0, 6'd5, 5'd9);
    wq.push_back('{3'b001, 6'd5, 5'd9, t + 2});
    @(negedge clk);
    wr_req = '0;
    n_total++;
    if (wr_ready !== 3'b110) $display("FAIL single_ready_busy: got %b, required 110", wr_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (wr_ready !== 3'b111) $display("FAIL single_ready_back: got %b, required 111", wr_ready);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (wq.size() != 0) $display("FAIL single_drain: got %0d writes outstanding, required 0", wq.size());
    else n_pass++;
  endtask

  task automatic test_contention();
    int t;
    @(negedge clk);
    t = cyc;
    set_wr(0, 6'd10, 5'd1);
    set_wr(1, 6'd20, 5'd2);
    set_wr(2, 6'd30, 5'd3);
    wq.push_back('{3'b010, 6'd20, 5'd2, t + 2});
    wq.push_back('{3'b100, 6'd30, 5'd3, t + 3});
    wq.push_back('{3'b001, 6'd10, 5'd1, t + 4});
    @(negedge clk);
    wr_req = '0;
    n_total++;
    if (wr_ready !== 3'b000) $display("FAIL contention_ready: got %b, required 000", wr_ready);
    else n_pass++;
    repeat (6) @(negedge clk);
    n_total++;
    if (wq.size() != 0) $display("FAIL contention_drain: got %0d writes outstanding, required 0", wq.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    int t;
    @(negedge clk);
    t = cyc;
    set_wr(2, 6'd40, 5'd7);
    wq.push_back('{3'b100, 6'd40, 5'd7, t + 2});
    @(negedge clk);
    n_total++;
    if (wr_ready !== 3'b011) $display("FAIL overflow_ready: got %b, required 011", wr_ready);
    else n_pass++;
    set_wr(2, 6'd41, 5'd8);
    @(negedge clk);
    wr_req = '0;
    n_total++;
    if (wr_overflow !== 1'b1) $display("FAIL overflow_flag: got %b, required 1", wr_overflow);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_total++;
    if (wr_overflow !== 1'b1 || wq.size() != 0)
      $display("FAIL overflow_sticky_drain: got ovf=%b outstanding=%0d, required 1 and 0", wr_overflow, wq.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t;
    @(negedge clk);
    t = cyc;
    set_wr(0, 6'd1, 5'd11);
    wq.push_back('{3'b001, 6'd1, 5'd11, t + 2});
    @(negedge clk);
    wr_req = '0;
    set_wr(1, 6'd2, 5'd12);
    wq.push_back('{3'b010, 6'd2, 5'd12, t + 3});
    @(negedge clk);
    wr_req = '0;
    n_total++;
    if (wr_ready[0] !== 1'b1) $display("FAIL b2b_ready_in_ack_cycle: got %b, required 1", wr_ready[0]);
    else n_pass++;
    set_wr(2, 6'd3, 5'd13);
    set_wr(0, 6'd4, 5'd14);
    wq.push_back('{3'b100, 6'd3, 5'd13, t + 4});
    wq.push_back('{3'b001, 6'd4, 5'd14, t + 5});
    @(negedge clk);
    wr_req = '0;
    repeat (6) @(negedge clk);
    n_total++;
    if (wq.size() != 0) $display("FAIL b2b_drain: got %0d writes outstanding, required 0", wq.size());
    else n_pass++;
  endtask

  task automatic test_scan();
    int  t;
    logic exp_busy;
    @(negedge clk);
    t = cyc;
    scan_start = 1'b1;
    scan_len   = 7'd4;
    rd_req     = 1'b1;
    rd_addr    = 6'd7;
    for (int j = 0; j < 4; j++) rq.push_back('{0, 6'(j), t + 2 + j});
    rq.push_back('{2, 6'd0, t + 6});
    rq.push_back('{1, 6'd7, t + 8});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      scan_start = 1'b0;
      exp_busy = (k <= 5);
      n_total++;
      if (scan_busy !== exp_busy)
        $display("FAIL scan_busy: got %b at offset %0d, required %b", scan_busy, k, exp_busy);
      else n_pass++;
      if (rd_valid === 1'b1) rd_req = 1'b0;
    end
    n_total++;
    if (rq.size() != 0 || rd_req !== 1'b0)
      $display("FAIL scan_drain: got %0d events outstanding rd_req=%b, required 0 and 0", rq.size(), rd_req);
    else n_pass++;
    // zero-length scan
    @(negedge clk);
    t = cyc;
    scan_start = 1'b1;
    scan_len   = '0;
    rq.push_back('{2, 6'd0, t + 1});
    @(negedge clk);
    scan_start = 1'b0;
    n_total++;
    if (scan_busy !== 1'b0) $display("FAIL scan_zero_busy: got %b, required 0", scan_busy);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if (rq.size() != 0) $display("FAIL scan_zero_drain: got %0d events outstanding, required 0", rq.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t;
    @(negedge clk);
    t = cyc;
    scan_start = 1'b1;
    scan_len   = 7'd8;
    rq.push_back('{0, 6'd0, t + 2});
    rq.push_back('{0, 6'd1, t + 3});
    @(negedge clk);
    scan_start = 1'b0;
    @(negedge clk);
    set_wr(1, 6'd50, 5'd21);
    @(negedge clk);
    wr_req = '0;
    n_total++;
    if (regfile_r_address !== 6'd2 || wr_ready !== 3'b101)
      $display("FAIL midreset_setup: got raddr=%0d ready=%b, required 2 and 101", regfile_r_address, wr_ready);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({scan_busy, scan_valid, scan_done, regfile_w_enable} !== 4'b0 || wr_ready !== 3'b111 || wr_overflow !== 1'b0)
      $display("FAIL midreset_idle: got busy=%b valid=%b done=%b wen=%b ready=%b ovf=%b, required 0 0 0 0 111 0",
               scan_busy, scan_valid, scan_done, regfile_w_enable, wr_ready, wr_overflow);
    else n_pass++;
    repeat (12) @(negedge clk);
    n_total++;
    if (rq.size() != 0 || wq.size() != 0)
      $display("FAIL midreset_drain: got read=%0d write=%0d outstanding, required 0", rq.size(), wq.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_overflow();
    test_back_to_back();
    test_scan();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
